uart_rx_param: RTL and testbench

Parametrised UART receiver with a single clock domain, an internal bit-rate counter, a configurable frame format and a one-entry output holding register with a valid/ready handshake. It samples the asynchronous `UART_RX` line through a 2-flop synchroniser, reconstructs frames LSB-first, and flags parity, framing and overrun errors. It sits between the board RX pin and the CPU-side peripheral bus or FIFO.

---
 rtl/uart_rx_param.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: UART receiver with a 2-flop line synchroniser, mid-bit sampling and a one-entry output register.
// Latency: data_valid rises 2 + CLKS_PER_BIT/2 + N*CLKS_PER_BIT + 1 cycles after the start edge is captured.
// Backpressure: a frame finishing while the held word is unread is dropped and flagged by the sticky overrun bit.
module uart_rx_param #(
   parameter int CLKS_PER_BIT = 10417,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 sysclk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 UART_RX,
   output logic [DATA_BITS-1:0] data,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);
   localparam logic          LAST_STOP = (STOP_BITS == 2);
   localparam logic          ODD       = (PARITY == 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP,
      S_BREAK
   } state_t;

   state_t               state, state_n;
   logic                 sync1, rx_s;
   logic [CW-1:0]        cnt, cnt_n;
   logic [IW-1:0]        idx, idx_n;
   logic                 stop_idx, stop_idx_n;
   logic [DATA_BITS-1:0] sh, sh_n;
   logic                 perr_f, perr_n;
   logic                 ferr_f, ferr_n;
   logic                 commit, commit_n;
   logic                 tick;
   logic                 take;

   // counter expiry marks a sample point
   assign tick = (cnt == '0);
   // the consumer empties the holding register this cycle
   assign take = data_valid && data_ready;

   // two-flop synchroniser on the asynchronous line, idle high
   always_ff @(posedge sysclk) begin
      if (reset) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= UART_RX;
         rx_s  <= sync1;
      end
   end

   // frame state register and datapath; busy mirrors the next state so it is registered
   always_ff @(posedge sysclk) begin
      if (reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         idx      <= '0;
         stop_idx <= 1'b0;
         sh       <= '0;
         perr_f   <= 1'b0;
         ferr_f   <= 1'b0;
         commit   <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         idx      <= idx_n;
         stop_idx <= stop_idx_n;
         sh       <= sh_n;
         perr_f   <= perr_n;
         ferr_f   <= ferr_n;
         commit   <= commit_n;
         busy     <= (state_n != S_IDLE);
      end
   end

   // next-state: sample at each terminal count and reload, so sample spacing never drifts
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      idx_n      = idx;
      stop_idx_n = stop_idx;
      sh_n       = sh;
      perr_n     = perr_f;
      ferr_n     = ferr_f;
      commit_n   = 1'b0;
      if (!enable) begin
         state_n    = S_IDLE;
         cnt_n      = '0;
         idx_n      = '0;
         stop_idx_n = 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!rx_s) begin
                  state_n = S_START;
                  cnt_n   = HALF_LOAD;
               end
            end
            S_START: begin
               if (!tick) begin
                  cnt_n = cnt - CW'(1);
               end else if (rx_s) begin
                  // line went back high before mid start bit: glitch, not a frame
                  state_n = S_IDLE;
               end else begin
                  state_n    = S_DATA;
                  cnt_n      = FULL_LOAD;
                  idx_n      = '0;
                  stop_idx_n = 1'b0;
                  perr_n     = 1'b0;
                  ferr_n     = 1'b0;
               end
            end
            S_DATA: begin
               if (!tick) begin
                  cnt_n = cnt - CW'(1);
               end else begin
                  sh_n  = {rx_s, sh[DATA_BITS-1:1]};
                  cnt_n = FULL_LOAD;
                  if (idx == LAST_IDX) begin
                     idx_n   = '0;
                     state_n = (PARITY != 0) ? S_PAR : S_STOP;
                  end else begin
                     idx_n = idx + IW'(1);
                  end
               end
            end
            S_PAR: begin
               if (!tick) begin
                  cnt_n = cnt - CW'(1);
               end else begin
                  perr_n  = ((^sh) ^ rx_s) != ODD;
                  cnt_n   = FULL_LOAD;
                  state_n = S_STOP;
               end
            end
            S_STOP: begin
               if (!tick) begin
                  cnt_n = cnt - CW'(1);
               end else begin
                  if (!rx_s) begin
                     ferr_n = 1'b1;
                  end
                  if (stop_idx == LAST_STOP) begin
                     // leave mid stop bit so a following start edge is not missed
                     commit_n   = 1'b1;
                     cnt_n      = '0;
                     stop_idx_n = 1'b0;
                     state_n    = (ferr_f || !rx_s) ? S_BREAK : S_IDLE;
                  end else begin
                     stop_idx_n = 1'b1;
                     cnt_n      = FULL_LOAD;
                  end
               end
            end
            S_BREAK: begin
               // a held-low line must return high before another start is accepted
               if (rx_s) begin
                  state_n = S_IDLE;
               end
            end
            default: begin
               state_n = S_IDLE;
            end
         endcase
      end
   end

   // one-entry holding register: commit loads it unless full and not being drained
   always_ff @(posedge sysclk) begin
      if (reset) begin
         data       <= '0;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else if (commit) begin
         if (!data_valid || data_ready) begin
            data       <= sh;
            parity_err <= perr_f;
            frame_err  <= ferr_f;
            data_valid <= 1'b1;
            if (take) begin
               overrun <= 1'b0;
            end
         end else begin
            overrun <= 1'b1;
         end
      end else if (take) begin
         data_valid <= 1'b0;
         overrun    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: drives an 8N1 and an 8E1 receiver (16 clocks per bit) with serial frames
// and compares the held word and flags against expectations derived from the frame contents.
module tb_uart_rx_param;

   localparam int C = 16;

   logic       sysclk = 1'b0;
   logic       reset;
   logic [1:0] enable;
   logic [1:0] line;
   logic [1:0] ready;
   logic [7:0] dat [2];
   logic [1:0] dv, perr, ferr, ovr, busy;

   int         cyc = 0;
   int         rise_cyc [2] = '{0, 0};
   logic [1:0] dv_q = 2'b00;
   int         n_checks;
   int         n_fail;

   always #5 sysclk = ~sysclk;

   always @(posedge sysclk) cyc <= cyc + 1;

   // note the cycle on which each data_valid rises
   always @(negedge sysclk) begin
      for (int u = 0; u < 2; u++) begin
         if (dv[u] === 1'b1 && dv_q[u] !== 1'b1) rise_cyc[u] = cyc;
      end
      dv_q = dv;
   end

   uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_8n1 (
      .sysclk(sysclk), .reset(reset), .enable(enable[0]), .UART_RX(line[0]),
      .data(dat[0]), .data_valid(dv[0]), .data_ready(ready[0]),
      .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]), .busy(busy[0]));

   uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_8e1 (
      .sysclk(sysclk), .reset(reset), .enable(enable[1]), .UART_RX(line[1]),
      .data(dat[1]), .data_valid(dv[1]), .data_ready(ready[1]),
      .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1]), .busy(busy[1]));

   task automatic tick(input int n);
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   // serialise one frame; unit 1 carries an even parity bit, optionally inverted
   task automatic send_frame(input int u, input logic [7:0] w, input bit bad_par, input bit stop_low);
      bit q[$];
      q.push_back(1'b0);
      for (int i = 0; i < 8; i++) q.push_back(w[i]);
      if (u == 1) q.push_back(1'(($countones(w) % 2)) ^ bad_par);
      q.push_back(!stop_low);
      foreach (q[i]) begin
         line[u] = q[i];
         tick(C);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(3);
      for (int u = 0; u < 2; u++) begin
         n_checks++;
         if (dat[u] !== 8'h00) begin n_fail++; $display("FAIL reset_data u%0d: got %h want 00", u, dat[u]); end
         n_checks++;
         if ({dv[u], perr[u], ferr[u], ovr[u], busy[u]} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags u%0d: got %b want 00000", u, {dv[u], perr[u], ferr[u], ovr[u], busy[u]});
         end
      end
      reset = 1'b0;
      tick(2);
   endtask

   task automatic test_8n1_latency();
      int c0;
      int exp_lat;
      // the line changes one edge before the capturing edge, hence the leading 1
      exp_lat = 1 + 2 + C / 2 + 9 * C + 1;
      c0 = cyc;
      send_frame(0, 8'hA5, 1'b0, 1'b0);
      n_checks++;
      if (rise_cyc[0] - c0 !== exp_lat) begin n_fail++; $display("FAIL latency_8n1: got %0d want %0d", rise_cyc[0] - c0, exp_lat); end
      n_checks++;
      if (dat[0] !== 8'hA5) begin n_fail++; $display("FAIL data_8n1: got %h want a5", dat[0]); end
      n_checks++;
      if ({dv[0], perr[0], ferr[0], ovr[0]} !== 4'b1000) begin
         n_fail++; $display("FAIL flags_8n1: got %b want 1000", {dv[0], perr[0], ferr[0], ovr[0]});
      end
      ready[0] = 1'b1;
      tick(1);
      ready[0] = 1'b0;
      n_checks++;
      if (dv[0] !== 1'b0) begin n_fail++; $display("FAIL handshake_8n1: got %b want 0", dv[0]); end
   endtask

   task automatic test_parity_8e1();
      int c0;
      int exp_lat;
      exp_lat = 1 + 2 + C / 2 + 10 * C + 1;
      c0 = cyc;
      send_frame(1, 8'h3C, 1'b0, 1'b0);
      n_checks++;
      if (rise_cyc[1] - c0 !== exp_lat) begin n_fail++; $display("FAIL latency_8e1: got %0d want %0d", rise_cyc[1] - c0, exp_lat); end
      n_checks++;
      if ({dat[1], dv[1], perr[1], ferr[1]} !== {8'h3C, 3'b100}) begin
         n_fail++; $display("FAIL parity_good: got %h/%b want 3c/100", dat[1], {dv[1], perr[1], ferr[1]});
      end
      ready[1] = 1'b1; tick(1); ready[1] = 1'b0;
      send_frame(1, 8'h3C, 1'b1, 1'b0);
      n_checks++;
      if ({dat[1], dv[1], perr[1], ferr[1]} !== {8'h3C, 3'b110}) begin
         n_fail++; $display("FAIL parity_bad: got %h/%b want 3c/110", dat[1], {dv[1], perr[1], ferr[1]});
      end
      ready[1] = 1'b1; tick(1); ready[1] = 1'b0;
   endtask

   task automatic test_framing_break();
      bit dropped;
      send_frame(0, 8'h00, 1'b0, 1'b1);
      dropped = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (busy[0] !== 1'b1) dropped = 1'b1;
         tick(1);
      end
      n_checks++;
      if (dropped) begin n_fail++; $display("FAIL break_busy: got busy low want held high"); end
      n_checks++;
      if ({dat[0], dv[0], perr[0], ferr[0]} !== {8'h00, 3'b101}) begin
         n_fail++; $display("FAIL break_frame: got %h/%b want 00/101", dat[0], {dv[0], perr[0], ferr[0]});
      end
      line[0] = 1'b1;
      tick(4);
      n_checks++;
      if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL break_release: got busy %b want 0", busy[0]); end
      ready[0] = 1'b1; tick(1); ready[0] = 1'b0;
      tick(300);
      n_checks++;
      if ({dv[0], ovr[0]} !== 2'b00) begin n_fail++; $display("FAIL break_second_frame: got %b want 00", {dv[0], ovr[0]}); end
   endtask

   task automatic test_overrun();
      send_frame(0, 8'h11, 1'b0, 1'b0);
      send_frame(0, 8'h22, 1'b0, 1'b0);
      n_checks++;
      if ({dat[0], dv[0], ovr[0]} !== {8'h11, 2'b11}) begin
         n_fail++; $display("FAIL overrun_set: got %h/%b want 11/11", dat[0], {dv[0], ovr[0]});
      end
      ready[0] = 1'b1; tick(1); ready[0] = 1'b0;
      n_checks++;
      if ({dv[0], ovr[0]} !== 2'b00) begin n_fail++; $display("FAIL overrun_clear: got %b want 00", {dv[0], ovr[0]}); end
      send_frame(0, 8'h11, 1'b0, 1'b0);
      fork
         send_frame(0, 8'h22, 1'b0, 1'b0);
         begin
            tick(155);
            n_checks++;
            if ({dat[0], dv[0], ovr[0]} !== {8'h11, 2'b10}) begin
               n_fail++; $display("FAIL precommit_hold: got %h/%b want 11/10", dat[0], {dv[0], ovr[0]});
            end
            ready[0] = 1'b1;
            tick(1);
            ready[0] = 1'b0;
            n_checks++;
            if ({dat[0], dv[0], ovr[0]} !== {8'h22, 2'b10}) begin
               n_fail++; $display("FAIL commit_with_take: got %h/%b want 22/10", dat[0], {dv[0], ovr[0]});
            end
         end
      join
      ready[0] = 1'b1; tick(1); ready[0] = 1'b0;
   endtask

   task automatic test_false_start();
      line[0] = 1'b0;
      tick(4);
      line[0] = 1'b1;
      n_checks++;
      if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL glitch_detect: got busy %b want 1", busy[0]); end
      tick(200);
      n_checks++;
      if ({busy[0], dv[0], perr[0], ferr[0], ovr[0]} !== 5'b0) begin
         n_fail++; $display("FAIL false_start: got %b want 00000", {busy[0], dv[0], perr[0], ferr[0], ovr[0]});
      end
   endtask

   task automatic test_abort_enable();
      logic [7:0] w;
      w = 8'($urandom);
      fork
         send_frame(0, w, 1'b0, 1'b0);
         begin
            tick(4 * C + C / 2);
            n_checks++;
            if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL abort_en_busy_before: got %b want 1", busy[0]); end
            enable[0] = 1'b0;
            tick(1);
            n_checks++;
            if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL abort_en_busy_after: got %b want 0", busy[0]); end
         end
      join
      enable[0] = 1'b1;
      tick(2 * C);
      n_checks++;
      if (dv[0] !== 1'b0) begin n_fail++; $display("FAIL abort_en_no_frame: got %b want 0", dv[0]); end
      send_frame(0, 8'h5A, 1'b0, 1'b0);
      n_checks++;
      if ({dat[0], dv[0], perr[0], ferr[0]} !== {8'h5A, 3'b100}) begin
         n_fail++; $display("FAIL abort_en_next: got %h/%b want 5a/100", dat[0], {dv[0], perr[0], ferr[0]});
      end
      ready[0] = 1'b1; tick(1); ready[0] = 1'b0;
   endtask

   task automatic test_abort_reset();
      send_frame(0, 8'hC3, 1'b0, 1'b0);
      send_frame(0, 8'h3C, 1'b0, 1'b0);
      fork
         send_frame(0, 8'($urandom), 1'b0, 1'b0);
         begin
            tick(4 * C + C / 2);
            n_checks++;
            if ({dat[0], dv[0], ovr[0], busy[0]} !== {8'hC3, 3'b111}) begin
               n_fail++; $display("FAIL abort_rst_before: got %h/%b want c3/111", dat[0], {dv[0], ovr[0], busy[0]});
            end
            reset = 1'b1;
            tick(1);
            n_checks++;
            if ({dat[0], dv[0], perr[0], ferr[0], ovr[0], busy[0]} !== 13'b0) begin
               n_fail++; $display("FAIL abort_rst_outputs: got %h/%b want 00/00000", dat[0], {dv[0], perr[0], ferr[0], ovr[0], busy[0]});
            end
         end
      join
      reset = 1'b0;
      tick(2 * C);
      n_checks++;
      if ({dv[0], busy[0]} !== 2'b00) begin n_fail++; $display("FAIL abort_rst_no_frame: got %b want 00", {dv[0], busy[0]}); end
      send_frame(0, 8'h5A, 1'b0, 1'b0);
      n_checks++;
      if ({dat[0], dv[0], perr[0], ferr[0]} !== {8'h5A, 3'b100}) begin
         n_fail++; $display("FAIL abort_rst_next: got %h/%b want 5a/100", dat[0], {dv[0], perr[0], ferr[0]});
      end
      ready[0] = 1'b1; tick(1); ready[0] = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++) begin
         int u;
         logic [7:0] w;
         bit bp;
         bit sl;
         u  = i % 2;
         w  = 8'($urandom);
         bp = (u == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         sl = ($urandom_range(0, 3) == 0);
         send_frame(u, w, bp, sl);
         line[u] = 1'b1;
         tick(3 * C);
         n_checks++;
         if ({dat[u], dv[u], perr[u], ferr[u], ovr[u]} !== {w, 1'b1, bp, sl, 1'b0}) begin
            n_fail++;
            $display("FAIL random_frame %0d u%0d: got %h/%b want %h/%b", i, u, dat[u],
                     {dv[u], perr[u], ferr[u], ovr[u]}, w, {1'b1, bp, sl, 1'b0});
         end
         ready[u] = 1'b1; tick(1); ready[u] = 1'b0;
         n_checks++;
         if (dv[u] !== 1'b0) begin n_fail++; $display("FAIL random_take %0d u%0d: got %b want 0", i, u, dv[u]); end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      enable   = 2'b11;
      line     = 2'b11;
      ready    = 2'b00;
      test_reset();
      test_8n1_latency();
      test_parity_8e1();
      test_framing_break();
      test_overrun();
      test_false_start();
      test_abort_enable();
      test_abort_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
